// File: rtl/activity_tracker_gen2_if.sv
// Handshake bundle between the strobe conditioning, the tracker core and the
// seven-segment driver.
interface activity_tracker_gen2_if;
    logic       step_in;
    logic       tick_in;
    logic       clear;
    logic       mode_auto;
    logic [1:0] mode_sel;
    logic [1:0] disp_mode;
    logic [4:0] bcd3;
    logic [4:0] bcd2;
    logic [4:0] bcd1;
    logic [4:0] bcd0;
    logic       disp_valid;
    logic       si;
    logic [7:0] steps_per_sec;

    modport master (
        output step_in, tick_in, clear, mode_auto, mode_sel,
        input  disp_mode, bcd3, bcd2, bcd1, bcd0, disp_valid, si, steps_per_sec
    );

    modport slave (
        input  step_in, tick_in, clear, mode_auto, mode_sel,
        output disp_mode, bcd3, bcd2, bcd1, bcd0, disp_valid, si, steps_per_sec
    );
endinterface

// File: rtl/activity_tracker_gen2.sv
// Pedometer core: step, distance, window and high-activity metrics, shown one
// at a time through a shared serial double-dabble converter.
module activity_tracker_gen2 #(
    parameter int CNT_W          = 16,
    parameter int DIST_SHIFT     = 11,
    parameter int LOW_THR        = 32,
    parameter int HIGH_THR       = 64,
    parameter int WINDOW_SECS    = 9,
    parameter int MIN_RUN        = 60,
    parameter int DISPLAY_PERIOD = 2,
    parameter int DISP_MAX       = 9999
) (
    input  logic                   step_clk,
    input  logic                   reset,
    activity_tracker_gen2_if.slave bus
);
    localparam int VAL_W = 14;
    localparam int SR_W  = VAL_W + 16;
    localparam int WIN_W = $clog2(WINDOW_SECS + 1);
    localparam int ROT_W = (DISPLAY_PERIOD > 1) ? $clog2(DISPLAY_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    logic [CNT_W-1:0] total;
    logic [15:0]      sec_steps;
    logic [16:0]      eff;
    logic [WIN_W-1:0] win_idx;
    logic [WIN_W-1:0] low_cnt;
    logic [7:0]       run;
    logic [VAL_W-1:0] hi_time;
    logic [ROT_W-1:0] rot_cnt;
    logic [VAL_W-1:0] conv_val;
    conv_state_t      state;
    logic [SR_W-1:0]  shreg;
    logic [3:0]       iter;
    logic [1:0]       snap_mode;
    logic             snap_half;

    function automatic logic [CNT_W-1:0] inc_total(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] inc_sec(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] inc_run(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] clamp_sps(input logic [16:0] v);
        return (v > 17'd255) ? 8'd255 : v[7:0];
    endfunction

    function automatic logic [VAL_W-1:0] add_hi(input logic [VAL_W-1:0] v, input logic [7:0] inc);
        logic [31:0] s;
        s = 32'(v) + 32'(inc);
        return (s > 32'(DISP_MAX)) ? VAL_W'(DISP_MAX) : VAL_W'(s);
    endfunction

    function automatic logic [VAL_W-1:0] clamp_val(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? VAL_W'(lim) : VAL_W'(v);
    endfunction

    // One add-3/shift iteration over {bcd[15:0], binary[VAL_W-1:0]}.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[VAL_W+4*i +: 4] > 4'd4)
                t[VAL_W+4*i +: 4] = t[VAL_W+4*i +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // A step coincident with the tick belongs to the closing second.
    assign eff = {1'b0, sec_steps} + {16'd0, bus.step_in};

    always_ff @(posedge step_clk or posedge reset) begin
        if (reset) begin
            total             <= '0;
            sec_steps         <= '0;
            win_idx           <= '0;
            low_cnt           <= '0;
            run               <= '0;
            hi_time           <= '0;
            bus.si            <= 1'b0;
            bus.steps_per_sec <= '0;
        end else if (bus.clear) begin
            total             <= '0;
            sec_steps         <= '0;
            win_idx           <= '0;
            low_cnt           <= '0;
            run               <= '0;
            hi_time           <= '0;
            bus.si            <= 1'b0;
            bus.steps_per_sec <= '0;
        end else begin
            if (bus.step_in)
                total <= inc_total(total);
            bus.si <= (32'(total) > 32'(DISP_MAX));
            if (bus.tick_in) begin
                sec_steps         <= '0;
                bus.steps_per_sec <= clamp_sps(eff);
                if (32'(win_idx) < 32'(WINDOW_SECS)) begin
                    win_idx <= win_idx + 1'b1;
                    if (eff > 17'(LOW_THR))
                        low_cnt <= low_cnt + 1'b1;
                end
                if (eff >= 17'(HIGH_THR)) begin
                    run <= inc_run(run);
                    if (32'(run) == 32'(MIN_RUN - 1))
                        hi_time <= add_hi(hi_time, 8'(MIN_RUN));
                    else if (32'(run) >= 32'(MIN_RUN))
                        hi_time <= add_hi(hi_time, 8'd1);
                end else begin
                    run <= '0;
                end
            end else if (bus.step_in) begin
                sec_steps <= inc_sec(sec_steps);
            end
        end
    end

    always_ff @(posedge step_clk or posedge reset) begin
        if (reset) begin
            rot_cnt       <= '0;
            bus.disp_mode <= 2'd0;
        end else if (!bus.mode_auto) begin
            rot_cnt       <= '0;
            bus.disp_mode <= bus.mode_sel;
        end else if (bus.tick_in) begin
            if (32'(rot_cnt) == 32'(DISPLAY_PERIOD - 1)) begin
                rot_cnt       <= '0;
                bus.disp_mode <= bus.disp_mode + 2'd1;
            end else begin
                rot_cnt <= rot_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        conv_val = '0;
        case (bus.disp_mode)
            2'd0:    conv_val = clamp_val(32'(total), 32'(DISP_MAX));
            2'd1:    conv_val = clamp_val(32'(total >> DIST_SHIFT), 32'd99);
            2'd2:    conv_val = VAL_W'(low_cnt);
            default: conv_val = hi_time;
        endcase
    end

    // IDLE(1) + SHIFT(14) + DONE(1): one display refresh every 16 cycles.
    always_ff @(posedge step_clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= '0;
            iter           <= '0;
            snap_mode      <= '0;
            snap_half      <= 1'b0;
            bus.bcd3       <= '0;
            bus.bcd2       <= '0;
            bus.bcd1       <= '0;
            bus.bcd0       <= '0;
            bus.disp_valid <= 1'b0;
        end else if (bus.clear) begin
            state          <= IDLE;
            shreg          <= '0;
            iter           <= '0;
            snap_mode      <= '0;
            snap_half      <= 1'b0;
            bus.bcd3       <= '0;
            bus.bcd2       <= '0;
            bus.bcd1       <= '0;
            bus.bcd0       <= '0;
            bus.disp_valid <= 1'b0;
        end else begin
            bus.disp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    shreg     <= {16'd0, conv_val};
                    snap_mode <= bus.disp_mode;
                    snap_half <= total[DIST_SHIFT-1];
                    iter      <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    shreg <= dd_step(shreg);
                    iter  <= iter + 4'd1;
                    if (iter == 4'd13)
                        state <= DONE;
                end
                default: begin
                    if (snap_mode == 2'd1) begin
                        bus.bcd3 <= {1'b0, shreg[VAL_W+4 +: 4]};
                        bus.bcd2 <= {1'b0, shreg[VAL_W +: 4]};
                        bus.bcd1 <= 5'h1F;
                        bus.bcd0 <= snap_half ? 5'd5 : 5'd0;
                    end else begin
                        bus.bcd3 <= {1'b0, shreg[VAL_W+12 +: 4]};
                        bus.bcd2 <= {1'b0, shreg[VAL_W+8 +: 4]};
                        bus.bcd1 <= {1'b0, shreg[VAL_W+4 +: 4]};
                        bus.bcd0 <= {1'b0, shreg[VAL_W +: 4]};
                    end
                    bus.disp_valid <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_activity_tracker_gen2.sv
// Bench for activity_tracker_gen2: directed stimulus, an abstract metric model
// and a per-cycle compare process.
module tb_activity_tracker_gen2;
    localparam int DISP_MAX       = 9999;
    localparam int LOW_THR        = 32;
    localparam int HIGH_THR       = 64;
    localparam int WINDOW_SECS    = 9;
    localparam int MIN_RUN        = 60;
    localparam int DISPLAY_PERIOD = 2;
    localparam int STEPS_PER_MILE = 2048;

    logic step_clk = 1'b0;
    logic reset    = 1'b1;

    activity_tracker_gen2_if bus();

    activity_tracker_gen2 dut (
        .step_clk(step_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 step_clk = ~step_clk;

    int checks   = 0;
    int failures = 0;

    // Abstract model: raw counts and histories, reduced to outputs on demand.
    int m_steps;
    int m_sec;
    int m_sps;
    int m_len;
    int m_hi_done;
    int m_base;
    int m_ticks;
    int win_q[$];
    bit m_si;
    bit dv_known;
    int dv_gap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int m_total();
        return (m_steps > 65535) ? 65535 : m_steps;
    endfunction

    function automatic int m_low();
        int n = 0;
        foreach (win_q[i]) if (win_q[i] > LOW_THR) n++;
        return n;
    endfunction

    function automatic int m_hi();
        int h = m_hi_done + ((m_len >= MIN_RUN) ? m_len : 0);
        return (h > DISP_MAX) ? DISP_MAX : h;
    endfunction

    function automatic int m_mode();
        return (m_base + m_ticks / DISPLAY_PERIOD) % 4;
    endfunction

    function automatic logic [19:0] exp_digits(input int mode);
        int v;
        int tot = m_total();
        case (mode)
            0: v = (tot > DISP_MAX) ? DISP_MAX : tot;
            1: begin
                v = tot / STEPS_PER_MILE;
                if (v > 99) v = 99;
                return {5'(v / 10), 5'(v % 10), 5'h1F, (((tot / 1024) % 2) == 1) ? 5'd5 : 5'd0};
            end
            2: v = m_low();
            default: v = m_hi();
        endcase
        return {5'(v / 1000), 5'((v / 100) % 10), 5'((v / 10) % 10), 5'(v % 10)};
    endfunction

    task automatic model_clear();
        m_steps = 0; m_sec = 0; m_sps = 0; m_len = 0; m_hi_done = 0; m_si = 0;
        win_q.delete();
        dv_known = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_base = 0; m_ticks = 0;
    endtask

    task automatic model_step(input bit s, input bit t, input bit c);
        int eff;
        if (bus.mode_auto) begin
            if (t) m_ticks++;
        end else begin
            m_base = bus.mode_sel; m_ticks = 0;
        end
        if (c) begin
            model_clear();
        end else begin
            m_si = (m_total() > DISP_MAX);
            if (t) begin
                eff   = m_sec + s;
                m_sps = (eff > 255) ? 255 : eff;
                if (win_q.size() < WINDOW_SECS) win_q.push_back(eff);
                if (eff >= HIGH_THR) m_len++;
                else begin
                    if (m_len >= MIN_RUN) m_hi_done += m_len;
                    m_len = 0;
                end
                m_sec = 0;
            end else begin
                m_sec += s;
            end
            m_steps += s;
        end
    endtask

    task automatic drive(input bit s, input bit t, input bit c);
        bus.step_in = s; bus.tick_in = t; bus.clear = c;
        @(posedge step_clk);
        model_step(s, t, c);
        #1;
        bus.step_in = 1'b0; bus.tick_in = 1'b0; bus.clear = 1'b0;
    endtask

    task automatic steps(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic sec(input int n);
        steps(n);
        drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_disp(input string name, input logic [1:0] mode, input logic [19:0] lit);
        logic [19:0] d;
        bus.mode_sel = mode;
        idle(40);
        d = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
        chk({name, "_mode"}, 32'(bus.disp_mode), 32'(mode));
        chk({name, "_lit"}, 32'(d), 32'(lit));
        chk({name, "_model"}, 32'(d), 32'(exp_digits(int'(mode))));
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge step_clk);
            if (!reset) begin
                chk("disp_mode", 32'(bus.disp_mode), 32'(m_mode()));
                chk("steps_per_sec", 32'(bus.steps_per_sec), 32'(m_sps));
                chk("si", 32'(bus.si), 32'(m_si));
                if (bus.disp_valid) begin
                    if (dv_known) chk("valid_period", 32'(dv_gap + 1), 32'd16);
                    dv_known = 1;
                    dv_gap   = 0;
                end else begin
                    dv_gap++;
                    if (!dv_known)
                        chk("digits_before_done", 32'({bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0}), 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int win_steps[10] = '{33, 32, 40, 0, 33, 33, 10, 64, 33, 50};
        int rot_exp[10]   = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
        bit got;

        bus.step_in = 1'b0; bus.tick_in = 1'b0; bus.clear = 1'b0;
        bus.mode_auto = 1'b0; bus.mode_sel = 2'd0;
        model_reset();
        #3;
        chk("rst_disp_mode", 32'(bus.disp_mode), 32'd0);
        chk("rst_digits", 32'({bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0}), 32'd0);
        chk("rst_valid", 32'(bus.disp_valid), 32'd0);
        chk("rst_si", 32'(bus.si), 32'd0);
        chk("rst_sps", 32'(bus.steps_per_sec), 32'd0);
        #9 reset = 1'b0;

        steps(1234);
        check_disp("total_1234", 2'd0, {5'd1, 5'd2, 5'd3, 5'd4});
        chk("si_low", 32'(bus.si), 32'd0);

        steps(8766);
        check_disp("total_10000", 2'd0, {5'd9, 5'd9, 5'd9, 5'd9});
        chk("si_high", 32'(bus.si), 32'd1);

        // Clear with a coincident step: the step must be dropped.
        drive(1'b1, 1'b0, 1'b1);
        steps(5120);
        check_disp("miles", 2'd1, {5'd0, 5'd2, 5'h1F, 5'd5});
        check_disp("total_5120", 2'd0, {5'd5, 5'd1, 5'd2, 5'd0});

        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) sec(win_steps[i]);
        check_disp("window_9", 2'd2, {5'd0, 5'd0, 5'd0, 5'd6});
        sec(win_steps[9]);
        chk("sps_50", 32'(bus.steps_per_sec), 32'd50);
        check_disp("window_10", 2'd2, {5'd0, 5'd0, 5'd0, 5'd6});

        drive(1'b0, 1'b0, 1'b1);
        steps(63);
        drive(1'b1, 1'b1, 1'b0);
        chk("coinc_sps", 32'(bus.steps_per_sec), 32'd64);
        sec(64);
        chk("next_sec_sps", 32'(bus.steps_per_sec), 32'd64);
        repeat (61) sec(64);
        check_disp("hi_63", 2'd3, {5'd0, 5'd0, 5'd6, 5'd3});
        sec(63);
        chk("low_sec_sps", 32'(bus.steps_per_sec), 32'd63);
        repeat (60) sec(64);
        check_disp("hi_123", 2'd3, {5'd0, 5'd1, 5'd2, 5'd3});

        bus.mode_sel = 2'd0;
        idle(2);
        bus.mode_auto = 1'b1;
        idle(1);
        chk("auto_start", 32'(bus.disp_mode), 32'd0);
        for (int i = 0; i < 10; i++) begin
            sec(0);
            chk("auto_seq", 32'(bus.disp_mode), 32'(rot_exp[i]));
        end
        sec(0);
        drive(1'b0, 1'b0, 1'b1);
        chk("clear_keeps_mode", 32'(bus.disp_mode), 32'd1);
        sec(0);
        chk("clear_keeps_rot", 32'(bus.disp_mode), 32'd2);

        bus.mode_auto = 1'b0;
        bus.mode_sel  = 2'd1;
        sec(50);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge step_clk);
            if (bus.disp_valid) got = 1'b1;
        end
        chk("valid_seen", 32'(got), 32'd1);
        idle(4);
        chk("pre_rst_mode", 32'(bus.disp_mode), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_mode", 32'(bus.disp_mode), 32'd0);
        chk("mid_rst_digits", 32'({bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0}), 32'd0);
        chk("mid_rst_valid", 32'(bus.disp_valid), 32'd0);
        chk("mid_rst_sps", 32'(bus.steps_per_sec), 32'd0);
        chk("mid_rst_si", 32'(bus.si), 32'd0);
        bus.mode_sel = 2'd0;
        #10 reset = 1'b0;
        check_disp("after_rst", 2'd0, {5'd0, 5'd0, 5'd0, 5'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
